riot_timer: RTL and testbench

Parametrised successor to the Atari 2600 PIA: a 6532-style RIOT block with two 8-bit I/O ports, data-direction registers, and an interval timer. The timer has a programmable prescaler, post-underflow fast-count and a timer interrupt flag. Optionally it adds PA7 edge detection with its own interrupt. It sits on the CPU bus beside the TIA and advances on the pixel-rate `enable_i` strobe.

---
 rtl/riot_timer.sv | 203 ++++++++++++++++++++
 tb/tb_riot_timer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/riot_timer.sv
// riot_timer -- 6532-style RIOT: two 8-bit I/O ports with data-direction
// registers and an interval timer (1/8/64/1024 prescaler, post-underflow
// fast count, timer interrupt). The timer advances on the enable_i strobe,
// one tick every CLK_PER_TICK strobes.
//
// Optional feature macro: RIOT_EDGE_IRQ_EN adds PA7 edge detection with
// its own flag (INSTAT bit6) and interrupt term. Without it, EDGECTL
// writes are ignored and no edge logic exists.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   enable_i            timer advance strobe
//   stb_i, we_i, adr_i  bus access strobe, write enable, register address
//   dat_i, dat_o        write data, registered read data
//   irq_o               registered level interrupt
//   pa_i, pb_i          port pin inputs
//   pa_o, pb_o          output registers ORA/ORB
//   pa_oe_o, pb_oe_o    output enables (DDRA/DDRB)
module riot_timer #(
  parameter int CLK_PER_TICK = 3,
  parameter int ADR_W        = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [ADR_W-1:0] adr_i,
  input  logic [7:0]       dat_i,
  output logic [7:0]       dat_o,
  output logic             irq_o,
  input  logic [7:0]       pa_i,
  input  logic [7:0]       pb_i,
  output logic [7:0]       pa_o,
  output logic [7:0]       pb_o,
  output logic [7:0]       pa_oe_o,
  output logic [7:0]       pb_oe_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_PER_TICK - 1);

  // Prescaler reload value for an interval code (0:1, 1:8, 2:64, 3:1024).
  function automatic logic [9:0] presc_init(input logic [1:0] code);
    case (code)
      2'd0:    presc_init = 10'd0;
      2'd1:    presc_init = 10'd7;
      2'd2:    presc_init = 10'd63;
      default: presc_init = 10'd1023;
    endcase
  endfunction

  // Address decode on adr_i[ADR_W-1:2]: group 0 = ports, 1 = timer/status
  // (and EDGECTL on writes), 5 = timer load without IE, 7 = with IE.
  logic [ADR_W-3:0] adr_hi;
  logic             rd, wr, sel_io, sel_tim, timer_wr;
  assign adr_hi   = adr_i[ADR_W-1:2];
  assign rd       = stb_i & ~we_i;
  assign wr       = stb_i & we_i;
  assign sel_io   = (adr_hi == (ADR_W-2)'(0));
  assign sel_tim  = (adr_hi == (ADR_W-2)'(1));
  assign timer_wr = wr & ((adr_hi == (ADR_W-2)'(5)) | (adr_hi == (ADR_W-2)'(7)));

  logic [7:0] ora_reg, orb_reg, ddra_reg, ddrb_reg;
  logic [7:0] intim_reg, intim_next;
  logic [9:0] presc_reg, presc_next;
  logic [1:0] ival_reg, ival_next;
  logic [7:0] div_reg, div_next;
  logic       timflag_reg, timflag_next;
  logic       timie_reg, timie_next;
  logic       pa7flag;
  logic       pa7_irq;
  logic       tick, underflow;
  logic [7:0] swcha, swchb;
  logic [7:0] rdata;
  logic       rd_hit;

  // Pin mixing: driven bits read back the output register, inputs read pins.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mix
      assign swcha[gi] = ddra_reg[gi] ? ora_reg[gi] : pa_i[gi];
      assign swchb[gi] = ddrb_reg[gi] ? orb_reg[gi] : pb_i[gi];
    end
  endgenerate

  assign tick      = enable_i & (div_reg == DIV_LAST);
  assign underflow = tick & (presc_reg == 10'd0) & (intim_reg == 8'h00);

  always_comb begin
    intim_next   = intim_reg;
    presc_next   = presc_reg;
    ival_next    = ival_reg;
    div_next     = div_reg;
    timflag_next = timflag_reg;
    timie_next   = timie_reg;
    if (enable_i) div_next = tick ? 8'd0 : div_reg + 8'd1;
    if (tick) begin
      if (presc_reg == 10'd0) begin
        intim_next = intim_reg - 8'd1;
        presc_next = presc_init(ival_reg);
        if (intim_reg == 8'h00) begin
          // After underflow the timer free-runs at interval 1.
          ival_next  = 2'd0;
          presc_next = 10'd0;
        end
      end else begin
        presc_next = presc_reg - 10'd1;
      end
    end
    if (rd & sel_tim & ~adr_i[0]) timflag_next = 1'b0;
    if (underflow) timflag_next = 1'b1;  // set beats a coincident INTIM read
    // A timer write overrides any same-cycle tick entirely.
    if (timer_wr) begin
      intim_next   = dat_i;
      ival_next    = adr_i[1:0];
      presc_next   = presc_init(adr_i[1:0]);
      div_next     = 8'd0;
      timflag_next = 1'b0;
      timie_next   = adr_i[3];
    end
  end

  always_comb begin
    rd_hit = rd & (sel_io | sel_tim);
    rdata  = 8'h00;
    case (adr_i[2:0])
      3'd0:       rdata = swcha;
      3'd1:       rdata = ddra_reg;
      3'd2:       rdata = swchb;
      3'd3:       rdata = ddrb_reg;
      3'd4, 3'd6: rdata = intim_reg;
      default:    rdata = {timflag_reg, pa7flag, 6'b0};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ora_reg     <= 8'h00;
      orb_reg     <= 8'h00;
      ddra_reg    <= 8'h00;
      ddrb_reg    <= 8'h00;
      intim_reg   <= 8'h00;
      presc_reg   <= 10'd1023;
      ival_reg    <= 2'd3;
      div_reg     <= 8'd0;
      timflag_reg <= 1'b0;
      timie_reg   <= 1'b0;
      dat_o       <= 8'h00;
      irq_o       <= 1'b0;
    end else begin
      if (wr & sel_io) begin
        case (adr_i[1:0])
          2'd0:    ora_reg  <= dat_i;
          2'd1:    ddra_reg <= dat_i;
          2'd2:    orb_reg  <= dat_i;
          default: ddrb_reg <= dat_i;
        endcase
      end
      intim_reg   <= intim_next;
      presc_reg   <= presc_next;
      ival_reg    <= ival_next;
      div_reg     <= div_next;
      timflag_reg <= timflag_next;
      timie_reg   <= timie_next;
      if (rd_hit) dat_o <= rdata;
      irq_o <= (timflag_reg & timie_reg) | pa7_irq;
    end
  end

`ifdef RIOT_EDGE_IRQ_EN
  logic [1:0] edgectl_reg;
  logic       pa7_q_reg;
  logic       pa7flag_reg;
  logic       pa7_edge;

  assign pa7_edge = edgectl_reg[0] ? (pa_i[7] & ~pa7_q_reg) : (~pa_i[7] & pa7_q_reg);
  assign pa7flag  = pa7flag_reg;
  assign pa7_irq  = pa7flag_reg & edgectl_reg[1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      edgectl_reg <= 2'b00;
      pa7_q_reg   <= pa_i[7];  // no spurious edge on leaving reset
      pa7flag_reg <= 1'b0;
    end else begin
      pa7_q_reg <= pa_i[7];
      if (wr & sel_tim) edgectl_reg <= dat_i[1:0];
      // Edge beats a coincident INSTAT read.
      if (pa7_edge) pa7flag_reg <= 1'b1;
      else if (rd & sel_tim & adr_i[0]) pa7flag_reg <= 1'b0;
    end
  end
`else
  assign pa7flag = 1'b0;
  assign pa7_irq = 1'b0;
`endif

  assign pa_o    = ora_reg;
  assign pb_o    = orb_reg;
  assign pa_oe_o = ddra_reg;
  assign pb_oe_o = ddrb_reg;

endmodule

// File: tb/tb_riot_timer.sv
module tb_riot_timer;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic       stb_i = 1'b0;
  logic       we_i = 1'b0;
  logic [6:0] adr_i = 7'h00;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       irq_o;
  logic [7:0] pa_i = 8'h00;
  logic [7:0] pb_i = 8'h00;
  logic [7:0] pa_o, pb_o, pa_oe_o, pb_oe_o;

  int total = 0;
  int bad = 0;
  logic [7:0] d;

  riot_timer #(.CLK_PER_TICK(3), .ADR_W(7)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .stb_i(stb_i),
    .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .irq_o(irq_o),
    .pa_i(pa_i), .pb_i(pb_i), .pa_o(pa_o), .pb_o(pb_o),
    .pa_oe_o(pa_oe_o), .pb_oe_o(pb_oe_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
    $display("check %s: got %h want %h", tag, obs, exp);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr(input logic [6:0] a, input logic [7:0] v, input logic en);
    stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = v; enable_i = en;
    @(negedge clk_i);
    stb_i = 1'b0; we_i = 1'b0; enable_i = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, input logic en, output logic [7:0] v);
    stb_i = 1'b1; we_i = 1'b0; adr_i = a; enable_i = en;
    @(negedge clk_i);
    stb_i = 1'b0; enable_i = 1'b0;
    v = dat_o;
  endtask

  task automatic pulses(input int n);
    enable_i = 1'b1;
    repeat (n) @(negedge clk_i);
    enable_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    check("rst_dat", dat_o, 8'h00);
    check("rst_irq", {7'b0, irq_o}, 8'h00);
    check("rst_pa_o", pa_o, 8'h00);
    check("rst_pa_oe", pa_oe_o, 8'h00);
    rd(7'h04, 1'b0, d); check("rst_intim", d, 8'h00);
    rd(7'h05, 1'b0, d); check("rst_instat", d, 8'h00);

    // Port mixing
    wr(7'h01, 8'hF0, 1'b0); wr(7'h00, 8'hA5, 1'b0); pa_i = 8'h3C;
    wr(7'h03, 8'h0F, 1'b0); wr(7'h02, 8'h5A, 1'b0); pb_i = 8'hC3;
    rd(7'h00, 1'b0, d); check("swcha", d, 8'hAC);
    check("pa_oe", pa_oe_o, 8'hF0);
    check("pa_o", pa_o, 8'hA5);
    rd(7'h02, 1'b0, d); check("swchb", d, 8'hCA);
    rd(7'h01, 1'b0, d); check("ddra", d, 8'hF0);
    rd(7'h08, 1'b0, d); check("unmapped_hold", dat_o, 8'hF0);

    // TIM8T with 0x02
    wr(7'h15, 8'h02, 1'b0);
    pulses(24); rd(7'h04, 1'b0, d); check("tim8_24", d, 8'h01);
    pulses(24); rd(7'h04, 1'b0, d); check("tim8_48", d, 8'h00);
    pulses(24); rd(7'h05, 1'b0, d); check("tim8_72_flag", d, 8'h80);
    check("tim8_72_irq", {7'b0, irq_o}, 8'h00);
    rd(7'h04, 1'b0, d); check("tim8_72", d, 8'hFF);
    pulses(3); rd(7'h04, 1'b0, d); check("tim8_75", d, 8'hFE);
    rd(7'h05, 1'b0, d); check("tim8_flag_clr", d, 8'h00);

    // Timer IRQ
    wr(7'h1C, 8'h00, 1'b0);
    pulses(3); check("irq_at_uf", {7'b0, irq_o}, 8'h00);
    @(negedge clk_i); check("irq_rise", {7'b0, irq_o}, 8'h01);
    rd(7'h04, 1'b0, d); check("irq_rd_intim", d, 8'hFF);
    check("irq_hold", {7'b0, irq_o}, 8'h01);
    @(negedge clk_i); check("irq_drop", {7'b0, irq_o}, 8'h00);
    wr(7'h1C, 8'h00, 1'b0); pulses(3); @(negedge clk_i);
    check("irq_rise2", {7'b0, irq_o}, 8'h01);
    wr(7'h14, 8'h10, 1'b0); @(negedge clk_i);
    check("irq_wr_drop", {7'b0, irq_o}, 8'h00);
    rd(7'h05, 1'b0, d); check("wr_clr_flag", d, 8'h00);

    // Timer write coincident with tick
    wr(7'h14, 8'h50, 1'b0); pulses(2);
    wr(7'h14, 8'h33, 1'b1);
    rd(7'h04, 1'b0, d); check("coll_wr", d, 8'h33);
    pulses(2); rd(7'h04, 1'b0, d); check("coll_div0", d, 8'h33);
    pulses(1); rd(7'h04, 1'b0, d); check("coll_dec", d, 8'h32);

    // INTIM read coincident with underflow
    wr(7'h14, 8'h00, 1'b0); pulses(2);
    rd(7'h04, 1'b1, d); check("coll_rd", d, 8'h00);
    rd(7'h05, 1'b0, d); check("coll_rd_flag", d, 8'h80);
    rd(7'h04, 1'b0, d); check("coll_rd_ff", d, 8'hFF);
    rd(7'h05, 1'b0, d); check("coll_rd_clr", d, 8'h00);

    // Reset mid-count, concurrent write ignored
    wr(7'h1F, 8'h80, 1'b0); pulses(5000);
    rd(7'h04, 1'b0, d); check("t1024_5000", d, 8'h7F);
    rst_ni = 1'b0; stb_i = 1'b1; we_i = 1'b1; adr_i = 7'h00; dat_i = 8'hFF; enable_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1; stb_i = 1'b0; we_i = 1'b0; enable_i = 1'b0;
    check("mrst_pa_o", pa_o, 8'h00);
    check("mrst_pb_o", pb_o, 8'h00);
    check("mrst_pa_oe", pa_oe_o, 8'h00);
    check("mrst_pb_oe", pb_oe_o, 8'h00);
    check("mrst_dat", dat_o, 8'h00);
    check("mrst_irq", {7'b0, irq_o}, 8'h00);
    rd(7'h04, 1'b0, d); check("mrst_intim", d, 8'h00);
    rd(7'h05, 1'b0, d); check("mrst_instat", d, 8'h00);

    // PA7 edge
    wr(7'h04, 8'h03, 1'b0);
    pa_i = 8'hBC; repeat (2) @(negedge clk_i);
`ifdef RIOT_EDGE_IRQ_EN
    check("edge_irq", {7'b0, irq_o}, 8'h01);
    rd(7'h05, 1'b0, d); check("edge_instat", d, 8'h40);
    rd(7'h05, 1'b0, d); check("edge_instat2", d, 8'h00);
    pa_i = 8'h3C; repeat (2) @(negedge clk_i);
    rd(7'h05, 1'b0, d); check("edge_fall", d, 8'h00);
    check("edge_irq_off", {7'b0, irq_o}, 8'h00);
`else
    check("noedge_irq", {7'b0, irq_o}, 8'h00);
    rd(7'h05, 1'b0, d); check("noedge_instat", d, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
